// File: rtl/pcis_mem_responder.sv
// pcis_mem_responder: AXI4 slave terminating the DMA PCIS port, backed by a
// 512-bit-wide on-chip memory. The write and read channels run concurrently,
// each with its own FSM, and each allows one burst in flight at a time.
//
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid && ready are both 1. Once a sender raises valid, it holds valid
// and the payload steady until that edge. Ready may change at any time, and
// no output here depends combinationally on the peer's valid.
module pcis_mem_responder #(
  parameter int LOG_DEPTH = 10,
  parameter int ID_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  // write address
  input  logic [ID_W-1:0]   sh_cl_dma_pcis_awid,
  input  logic [63:0]       sh_cl_dma_pcis_awaddr,
  input  logic [7:0]        sh_cl_dma_pcis_awlen,
  input  logic              sh_cl_dma_pcis_awvalid,
  output logic              cl_sh_dma_pcis_awready,
  // write data
  input  logic [511:0]      sh_cl_dma_pcis_wdata,
  input  logic [63:0]       sh_cl_dma_pcis_wstrb,
  input  logic              sh_cl_dma_pcis_wlast,
  input  logic              sh_cl_dma_pcis_wvalid,
  output logic              cl_sh_dma_pcis_wready,
  // write response
  output logic [ID_W-1:0]   cl_sh_dma_pcis_bid,
  output logic [1:0]        cl_sh_dma_pcis_bresp,
  output logic              cl_sh_dma_pcis_bvalid,
  input  logic              sh_cl_dma_pcis_bready,
  // read address
  input  logic [ID_W-1:0]   sh_cl_dma_pcis_arid,
  input  logic [63:0]       sh_cl_dma_pcis_araddr,
  input  logic [7:0]        sh_cl_dma_pcis_arlen,
  input  logic              sh_cl_dma_pcis_arvalid,
  output logic              cl_sh_dma_pcis_arready,
  // read data
  output logic [ID_W-1:0]   cl_sh_dma_pcis_rid,
  output logic [511:0]      cl_sh_dma_pcis_rdata,
  output logic [1:0]        cl_sh_dma_pcis_rresp,
  output logic              cl_sh_dma_pcis_rlast,
  output logic              cl_sh_dma_pcis_rvalid,
  input  logic              sh_cl_dma_pcis_rready,
  // FSM state visibility
  output logic [1:0]        o_dbg_wr_state,
  output logic              o_dbg_rd_state
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Backing store; contents are intentionally not reset.
  logic [511:0] r_mem [DEPTH];

  // ---------------- write side ----------------
  logic [1:0]           r_wr_state;
  logic [ID_W-1:0]      r_wr_id;
  logic [LOG_DEPTH-1:0] r_wr_idx;
  logic [7:0]           r_wr_len;
  logic [7:0]           r_wr_cnt;    // index of the current beat
  logic                 r_wr_extra;  // a beat beyond awlen arrived without wlast
  logic                 r_wr_err;

  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = cl_sh_dma_pcis_awready && sh_cl_dma_pcis_awvalid;
  assign w_w_hs  = cl_sh_dma_pcis_wready  && sh_cl_dma_pcis_wvalid;

  // Write FSM: latch the burst, count beats, then hold B until bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_id    <= '0;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_extra <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wr_id    <= sh_cl_dma_pcis_awid;
            r_wr_idx   <= sh_cl_dma_pcis_awaddr[LOG_DEPTH+5:6];
            r_wr_len   <= sh_cl_dma_pcis_awlen;
            r_wr_cnt   <= '0;
            r_wr_extra <= 1'b0;
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_wr_idx <= r_wr_idx + LOG_DEPTH'(1);
            if (sh_cl_dma_pcis_wlast) begin
              r_wr_err   <= (r_wr_cnt != r_wr_len) || r_wr_extra;
              r_wr_state <= W_RESP;
            end else begin
              if (r_wr_cnt == r_wr_len) r_wr_extra <= 1'b1;
              r_wr_cnt <= r_wr_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (sh_cl_dma_pcis_bready) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write; every accepted beat lands even on a bad burst.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < 64; b++) begin
        if (sh_cl_dma_pcis_wstrb[b]) r_mem[r_wr_idx][b*8 +: 8] <= sh_cl_dma_pcis_wdata[b*8 +: 8];
      end
    end
  end

  assign cl_sh_dma_pcis_awready = !rst && (r_wr_state == W_IDLE);
  assign cl_sh_dma_pcis_wready  = !rst && (r_wr_state == W_DATA);
  assign cl_sh_dma_pcis_bvalid  = !rst && (r_wr_state == W_RESP);
  assign cl_sh_dma_pcis_bid     = rst ? '0 : r_wr_id;
  assign cl_sh_dma_pcis_bresp   = (cl_sh_dma_pcis_bvalid && r_wr_err) ? 2'b10 : 2'b00;

  // ---------------- read side ----------------
  logic [0:0]           r_rd_state;
  logic [ID_W-1:0]      r_rd_id;
  logic [LOG_DEPTH-1:0] r_rd_idx;   // next word to fetch
  logic [7:0]           r_rd_len;
  logic [7:0]           r_rd_cnt;   // beat number of the next fetch
  logic                 r_rd_done;  // every beat of the burst has been fetched

  // Two-entry output queue, loaded straight from the registered memory read.
  logic [511:0] r_fifo_data [2];
  logic         r_fifo_last [2];
  logic         r_fifo_wp;
  logic         r_fifo_rp;
  logic [1:0]   r_fifo_cnt;

  logic w_ar_hs;
  logic w_rvalid;
  logic w_pop;
  logic w_issue;

  assign w_ar_hs  = cl_sh_dma_pcis_arready && sh_cl_dma_pcis_arvalid;
  assign w_rvalid = !rst && (r_fifo_cnt != 2'd0);
  assign w_pop    = w_rvalid && sh_cl_dma_pcis_rready;
  // Fetch only when a slot is free by the edge the data lands on.
  assign w_issue  = !rst && (r_rd_state == R_DATA) && !r_rd_done &&
                    ((r_fifo_cnt != 2'd2) || w_pop);

  // Read FSM and output-queue bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_id    <= '0;
      r_rd_idx   <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
      r_rd_done  <= 1'b0;
      r_fifo_wp  <= 1'b0;
      r_fifo_rp  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_id    <= sh_cl_dma_pcis_arid;
            r_rd_idx   <= sh_cl_dma_pcis_araddr[LOG_DEPTH+5:6];
            r_rd_len   <= sh_cl_dma_pcis_arlen;
            r_rd_cnt   <= '0;
            r_rd_done  <= 1'b0;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_issue) begin
            r_rd_idx <= r_rd_idx + LOG_DEPTH'(1);
            if (r_rd_cnt == r_rd_len) r_rd_done <= 1'b1;
            else                      r_rd_cnt  <= r_rd_cnt + 8'd1;
          end
          if (w_pop && cl_sh_dma_pcis_rlast) r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
      if (w_issue) r_fifo_wp <= ~r_fifo_wp;
      if (w_pop)   r_fifo_rp <= ~r_fifo_rp;
      case ({w_issue, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Registered memory read into the free queue slot; a same-cycle write to
  // this word is not visible, so a collision returns the old data.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_fifo_data[r_fifo_wp] <= r_mem[r_rd_idx];
      r_fifo_last[r_fifo_wp] <= (r_rd_cnt == r_rd_len);
    end
  end

  assign cl_sh_dma_pcis_arready = !rst && (r_rd_state == R_IDLE);
  assign cl_sh_dma_pcis_rvalid  = w_rvalid;
  assign cl_sh_dma_pcis_rdata   = w_rvalid ? r_fifo_data[r_fifo_rp] : '0;
  assign cl_sh_dma_pcis_rlast   = w_rvalid && r_fifo_last[r_fifo_rp];
  assign cl_sh_dma_pcis_rid     = rst ? '0 : r_rd_id;
  assign cl_sh_dma_pcis_rresp   = 2'b00;

  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state[0];

  // Address bits outside the word index are ignored by design.
  logic w_unused;
  assign w_unused = ^{sh_cl_dma_pcis_awaddr[63:LOG_DEPTH+6], sh_cl_dma_pcis_awaddr[5:0],
                      sh_cl_dma_pcis_araddr[63:LOG_DEPTH+6], sh_cl_dma_pcis_araddr[5:0]};

endmodule

// File: tb/tb_pcis_mem_responder.sv
// Directed bench for pcis_mem_responder: write/read bursts, byte strobes,
// read back-pressure, length-mismatch response, index wrap and mid-burst reset.
module tb_pcis_mem_responder;

  localparam int ID_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ID_W-1:0] sh_cl_dma_pcis_awid = '0;
  logic [63:0]     sh_cl_dma_pcis_awaddr = '0;
  logic [7:0]      sh_cl_dma_pcis_awlen = '0;
  logic            sh_cl_dma_pcis_awvalid = 1'b0;
  logic            cl_sh_dma_pcis_awready;
  logic [511:0]    sh_cl_dma_pcis_wdata = '0;
  logic [63:0]     sh_cl_dma_pcis_wstrb = '0;
  logic            sh_cl_dma_pcis_wlast = 1'b0;
  logic            sh_cl_dma_pcis_wvalid = 1'b0;
  logic            cl_sh_dma_pcis_wready;
  logic [ID_W-1:0] cl_sh_dma_pcis_bid;
  logic [1:0]      cl_sh_dma_pcis_bresp;
  logic            cl_sh_dma_pcis_bvalid;
  logic            sh_cl_dma_pcis_bready = 1'b0;
  logic [ID_W-1:0] sh_cl_dma_pcis_arid = '0;
  logic [63:0]     sh_cl_dma_pcis_araddr = '0;
  logic [7:0]      sh_cl_dma_pcis_arlen = '0;
  logic            sh_cl_dma_pcis_arvalid = 1'b0;
  logic            cl_sh_dma_pcis_arready;
  logic [ID_W-1:0] cl_sh_dma_pcis_rid;
  logic [511:0]    cl_sh_dma_pcis_rdata;
  logic [1:0]      cl_sh_dma_pcis_rresp;
  logic            cl_sh_dma_pcis_rlast;
  logic            cl_sh_dma_pcis_rvalid;
  logic            sh_cl_dma_pcis_rready = 1'b0;
  logic [1:0]      dbg_wr_state;
  logic            dbg_rd_state;

  pcis_mem_responder #(.LOG_DEPTH(10), .ID_W(ID_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sh_cl_dma_pcis_awid    (sh_cl_dma_pcis_awid),
    .sh_cl_dma_pcis_awaddr  (sh_cl_dma_pcis_awaddr),
    .sh_cl_dma_pcis_awlen   (sh_cl_dma_pcis_awlen),
    .sh_cl_dma_pcis_awvalid (sh_cl_dma_pcis_awvalid),
    .cl_sh_dma_pcis_awready (cl_sh_dma_pcis_awready),
    .sh_cl_dma_pcis_wdata   (sh_cl_dma_pcis_wdata),
    .sh_cl_dma_pcis_wstrb   (sh_cl_dma_pcis_wstrb),
    .sh_cl_dma_pcis_wlast   (sh_cl_dma_pcis_wlast),
    .sh_cl_dma_pcis_wvalid  (sh_cl_dma_pcis_wvalid),
    .cl_sh_dma_pcis_wready  (cl_sh_dma_pcis_wready),
    .cl_sh_dma_pcis_bid     (cl_sh_dma_pcis_bid),
    .cl_sh_dma_pcis_bresp   (cl_sh_dma_pcis_bresp),
    .cl_sh_dma_pcis_bvalid  (cl_sh_dma_pcis_bvalid),
    .sh_cl_dma_pcis_bready  (sh_cl_dma_pcis_bready),
    .sh_cl_dma_pcis_arid    (sh_cl_dma_pcis_arid),
    .sh_cl_dma_pcis_araddr  (sh_cl_dma_pcis_araddr),
    .sh_cl_dma_pcis_arlen   (sh_cl_dma_pcis_arlen),
    .sh_cl_dma_pcis_arvalid (sh_cl_dma_pcis_arvalid),
    .cl_sh_dma_pcis_arready (cl_sh_dma_pcis_arready),
    .cl_sh_dma_pcis_rid     (cl_sh_dma_pcis_rid),
    .cl_sh_dma_pcis_rdata   (cl_sh_dma_pcis_rdata),
    .cl_sh_dma_pcis_rresp   (cl_sh_dma_pcis_rresp),
    .cl_sh_dma_pcis_rlast   (cl_sh_dma_pcis_rlast),
    .cl_sh_dma_pcis_rvalid  (cl_sh_dma_pcis_rvalid),
    .sh_cl_dma_pcis_rready  (sh_cl_dma_pcis_rready),
    .o_dbg_wr_state         (dbg_wr_state),
    .o_dbg_rd_state         (dbg_rd_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errs   = 0;
  logic [511:0] wd [16];   // write beats to drive
  logic [63:0]  ws [16];   // matching strobes
  logic [511:0] re [16];   // expected read beats

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left just after a negedge) ----------------
  task automatic do_write(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                          input int nbeats, input int bdelay, input logic [1:0] exp_resp);
    int n;
    sh_cl_dma_pcis_awid = id; sh_cl_dma_pcis_awaddr = addr;
    sh_cl_dma_pcis_awlen = 8'(len); sh_cl_dma_pcis_awvalid = 1'b1;
    #1;
    n = 0;
    while (!cl_sh_dma_pcis_awready && n < 20) begin @(negedge clk); #1; n++; end
    check("aw_ready", 512'(cl_sh_dma_pcis_awready), 512'(1));
    @(negedge clk);
    sh_cl_dma_pcis_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      sh_cl_dma_pcis_wdata = wd[i]; sh_cl_dma_pcis_wstrb = ws[i];
      sh_cl_dma_pcis_wlast = (i == nbeats - 1); sh_cl_dma_pcis_wvalid = 1'b1;
      #1;
      n = 0;
      while (!cl_sh_dma_pcis_wready && n < 20) begin @(negedge clk); #1; n++; end
      check("w_ready", 512'(cl_sh_dma_pcis_wready), 512'(1));
      @(negedge clk);
    end
    sh_cl_dma_pcis_wvalid = 1'b0; sh_cl_dma_pcis_wlast = 1'b0;
    #1;
    n = 0;
    while (!cl_sh_dma_pcis_bvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("b_valid", 512'(cl_sh_dma_pcis_bvalid), 512'(1));
    check("b_id", 512'(cl_sh_dma_pcis_bid), 512'(id));
    check("b_resp", 512'(cl_sh_dma_pcis_bresp), 512'(exp_resp));
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk); #1;
      check("b_valid_held", 512'(cl_sh_dma_pcis_bvalid), 512'(1));
      check("b_id_held", 512'(cl_sh_dma_pcis_bid), 512'(id));
      check("b_resp_held", 512'(cl_sh_dma_pcis_bresp), 512'(exp_resp));
      check("aw_blocked", 512'(cl_sh_dma_pcis_awready), 512'(0));
    end
    sh_cl_dma_pcis_bready = 1'b1;
    @(negedge clk);
    sh_cl_dma_pcis_bready = 1'b0;
    #1;
    check("b_done", 512'(cl_sh_dma_pcis_bvalid), 512'(0));
    check("aw_reopen", 512'(cl_sh_dma_pcis_awready), 512'(1));
  endtask

  // toggle=0: rready always 1; toggle=1: rready 1,0,1,0,...
  task automatic do_read(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                         input int toggle);
    int n;
    int k;
    sh_cl_dma_pcis_arid = id; sh_cl_dma_pcis_araddr = addr;
    sh_cl_dma_pcis_arlen = 8'(len); sh_cl_dma_pcis_arvalid = 1'b1;
    #1;
    check("ar_ready", 512'(cl_sh_dma_pcis_arready), 512'(1));
    @(negedge clk);
    sh_cl_dma_pcis_arvalid = 1'b0;
    #1;
    check("r_lat_n1", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
    check("ar_busy", 512'(cl_sh_dma_pcis_arready), 512'(0));
    @(negedge clk); #1;
    check("r_lat_n2", 512'(cl_sh_dma_pcis_rvalid), 512'(1));
    k = 0; n = 0;
    while (k <= len && n < 200) begin
      sh_cl_dma_pcis_rready = (toggle == 0) ? 1'b1 : ((n % 2) == 0);
      #1;
      if (cl_sh_dma_pcis_rvalid) begin
        check("r_data", cl_sh_dma_pcis_rdata, re[k]);
        check("r_id", 512'(cl_sh_dma_pcis_rid), 512'(id));
        check("r_last", 512'(cl_sh_dma_pcis_rlast), 512'(k == len));
        check("r_resp", 512'(cl_sh_dma_pcis_rresp), 512'(0));
        if (sh_cl_dma_pcis_rready) k++;
      end
      @(negedge clk); #1;
      n++;
    end
    check("r_beats", 512'(k), 512'(len + 1));
    sh_cl_dma_pcis_rready = 1'b0;
    #1;
    check("r_idle", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
    check("ar_reopen", 512'(cl_sh_dma_pcis_arready), 512'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset: every output low / zero while rst is held.
    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", 512'(cl_sh_dma_pcis_awready), 512'(0));
    check("rst_wready", 512'(cl_sh_dma_pcis_wready), 512'(0));
    check("rst_bvalid", 512'(cl_sh_dma_pcis_bvalid), 512'(0));
    check("rst_arready", 512'(cl_sh_dma_pcis_arready), 512'(0));
    check("rst_rvalid", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
    check("rst_rlast", 512'(cl_sh_dma_pcis_rlast), 512'(0));
    check("rst_bid", 512'(cl_sh_dma_pcis_bid), 512'(0));
    check("rst_rid", 512'(cl_sh_dma_pcis_rid), 512'(0));
    check("rst_bresp", 512'(cl_sh_dma_pcis_bresp), 512'(0));
    check("rst_rdata", cl_sh_dma_pcis_rdata, 512'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_awready", 512'(cl_sh_dma_pcis_awready), 512'(1));
    check("post_rst_arready", 512'(cl_sh_dma_pcis_arready), 512'(1));
    @(negedge clk);

    // 1) 4-beat write to 0x40 (id 5), then read back with id 9.
    for (int i = 0; i < 4; i++) begin
      wd[i] = {16{32'(32'hC0DE0000 + i)}};
      ws[i] = '1;
      re[i] = {16{32'(32'hC0DE0000 + i)}};
    end
    do_write(16'h5, 64'h40, 3, 4, 0, 2'b00);
    @(negedge clk);
    do_read(16'h9, 64'h40, 3, 0);
    @(negedge clk);

    // 2) Byte strobe: word 5 all 0xFF, then byte 0 cleared.
    wd[0] = {64{8'hFF}}; ws[0] = '1;
    do_write(16'h1, 64'h140, 0, 1, 0, 2'b00);
    wd[0] = '0; ws[0] = 64'h1;
    do_write(16'h2, 64'h140, 0, 1, 0, 2'b00);
    re[0] = {{63{8'hFF}}, 8'h00};
    do_read(16'h3, 64'h140, 0, 0);
    @(negedge clk);

    // 3) 8-beat burst at word 16, read back with rready toggling.
    for (int i = 0; i < 8; i++) begin
      wd[i] = {64{8'(8'h30 + i)}};
      ws[i] = '1;
      re[i] = {64{8'(8'h30 + i)}};
    end
    do_write(16'h7, 64'h400, 7, 8, 0, 2'b00);
    do_read(16'hA, 64'h400, 7, 1);
    @(negedge clk);

    // 4) awlen 1 with wlast on beat 3, bready late: SLVERR, all beats written.
    for (int i = 0; i < 3; i++) begin
      wd[i] = {8{64'(64'hFACE_0000_0000_0000 + i)}};
      ws[i] = '1;
      re[i] = {8{64'(64'hFACE_0000_0000_0000 + i)}};
    end
    do_write(16'hBEEF, 64'h800, 1, 3, 5, 2'b10);
    do_read(16'h4, 64'h800, 2, 0);
    @(negedge clk);

    // 5) Index wrap: last word then word 0; high and low address bits ignored.
    wd[0] = {64{8'hA5}}; ws[0] = '1;
    wd[1] = {64{8'h5A}}; ws[1] = '1;
    do_write(16'h11, 64'hFFC0, 1, 2, 0, 2'b00);
    re[0] = {64{8'hA5}};
    re[1] = {64{8'h5A}};
    do_read(16'h12, 64'hFFC0, 1, 0);
    re[0] = {64{8'h5A}};
    do_read(16'h13, 64'h0000_0010_0000_0007, 0, 0);
    @(negedge clk);

    // 6) Reset during beat 2 of a 4-beat read from 0x40.
    sh_cl_dma_pcis_arid = 16'h21; sh_cl_dma_pcis_araddr = 64'h40;
    sh_cl_dma_pcis_arlen = 8'd3; sh_cl_dma_pcis_arvalid = 1'b1;
    @(negedge clk);
    sh_cl_dma_pcis_arvalid = 1'b0;
    sh_cl_dma_pcis_rready = 1'b1;
    @(negedge clk); #1;
    check("rr_beat0_valid", 512'(cl_sh_dma_pcis_rvalid), 512'(1));
    check("rr_beat0_data", cl_sh_dma_pcis_rdata, {16{32'hC0DE0000}});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_in_rst_rvalid", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
    check("rr_in_rst_rlast", 512'(cl_sh_dma_pcis_rlast), 512'(0));
    check("rr_in_rst_rdata", cl_sh_dma_pcis_rdata, 512'(0));
    check("rr_in_rst_arready", 512'(cl_sh_dma_pcis_arready), 512'(0));
    @(negedge clk); #1;
    check("rr_in_rst2_rvalid", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
    check("rr_in_rst2_rid", 512'(cl_sh_dma_pcis_rid), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_post_arready", 512'(cl_sh_dma_pcis_arready), 512'(1));
    check("rr_post_awready", 512'(cl_sh_dma_pcis_awready), 512'(1));
    for (int i = 0; i < 5; i++) begin
      check("rr_no_residual", 512'(cl_sh_dma_pcis_rvalid), 512'(0));
      @(negedge clk); #1;
    end
    sh_cl_dma_pcis_rready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/pcis_mem_responder.md
Name: pcis_mem_responder

Overview:
AXI4 slave that terminates the shell's DMA PCIS interface (host-initiated reads and writes into the CL). It is the responder counterpart of the CL's PCIM initiator path. Traffic is backed by an on-chip 512-bit-wide memory so host software can load and inspect buffers. Write and read channels run independently and concurrently.

Parameters:
LOG_DEPTH, 10, log2 of memory depth in 64-byte words (default 1024 words = 64 KiB)
ID_W, 16, width of AXI ID fields

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sh_cl_dma_pcis_awid  in  ID_W  write burst ID
sh_cl_dma_pcis_awaddr  in  64  write byte address; bits [5:0] ignored
sh_cl_dma_pcis_awlen  in  8  beats minus 1
sh_cl_dma_pcis_awvalid  in  1  AW valid
cl_sh_dma_pcis_awready  out  1  AW ready
sh_cl_dma_pcis_wdata  in  512  write data
sh_cl_dma_pcis_wstrb  in  64  byte enables
sh_cl_dma_pcis_wlast  in  1  last write beat
sh_cl_dma_pcis_wvalid  in  1  W valid
cl_sh_dma_pcis_wready  out  1  W ready
cl_sh_dma_pcis_bid  out  ID_W  response ID
cl_sh_dma_pcis_bresp  out  2  00 OKAY, 10 SLVERR
cl_sh_dma_pcis_bvalid  out  1  B valid
sh_cl_dma_pcis_bready  in  1  B ready
sh_cl_dma_pcis_arid  in  ID_W  read burst ID
sh_cl_dma_pcis_araddr  in  64  read byte address; bits [5:0] ignored
sh_cl_dma_pcis_arlen  in  8  beats minus 1
sh_cl_dma_pcis_arvalid  in  1  AR valid
cl_sh_dma_pcis_arready  out  1  AR ready
cl_sh_dma_pcis_rid  out  ID_W  read ID
cl_sh_dma_pcis_rdata  out  512  read data
cl_sh_dma_pcis_rresp  out  2  always 00
cl_sh_dma_pcis_rlast  out  1  last read beat
cl_sh_dma_pcis_rvalid  out  1  R valid
sh_cl_dma_pcis_rready  in  1  R ready

Behaviour:
- Memory: 2^LOG_DEPTH x 512b, simple dual-port. Word index = addr[LOG_DEPTH+5:6]; higher address bits are ignored. Bursts are INCR: the index increments by 1 per beat and wraps modulo depth. Size is always 64B. Contents are not reset.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, index and awlen; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb and increments the beat counter. On the wlast handshake go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. bresp=00 if beats == awlen+1, else 10; a mismatched burst still writes every accepted beat. bvalid, bid and bresp are held until bready; then return to W_IDLE.
  - Only one write is outstanding at a time: awready=0 outside W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake (cycle N), latch id, index and arlen; go to R_DATA.
  - R_DATA: first rvalid at cycle N+2, from the registered memory read. A 2-entry output skid buffer sustains 1 beat/cycle while rready=1. rdata, rid and rlast are stable while rvalid && !rready.
  - rlast=1 on beat arlen. After the rlast handshake return to R_IDLE; arready reasserts the next cycle. Only one read is outstanding.
- Collision: a read and a write to the same word in the same cycle returns the old data.
- Reset:
  - While rst=1: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0.
  - The first cycle after rst deasserts: awready=1, arready=1.
  - Reset mid-burst abandons the burst with no B/R issued.

Test Plan:
- AW addr 0x40, awlen 3, id 0x5; 4 beats D0..D3, full strb -> bvalid with bid 0x5, bresp 00. Then AR 0x40, arlen 3, id 0x9 -> D0..D3, rlast on beat 4 only, rid 0x9, first rvalid 2 cycles after the AR handshake.
- Write word 5 all 0xFF, then write word 5 with strb 64'h1, data 0 -> read word 5 returns byte0=0x00, bytes1..63=0xFF.
- 8-beat read with rready toggling 1,0,1,0 -> exactly 8 beats in order, rdata unchanged during every stall.
- awlen 1 but wlast on beat 3; bready held low 5 cycles -> bresp 10; bvalid and bid held; awready 0 until the B handshake.
- Default depth, awaddr 1023*64, awlen 1 -> second beat lands in word 0; readback confirms.
- Assert rst during beat 2 of a 4-beat read -> rvalid 0 while in reset; arready 1 on the first cycle after rst drops; no residual beats.
